// File: rtl/calc_program_driver.sv
// Program driver for the stack calculator: holds a short instruction list,
// replays it into the calculator after clearing it, and reports either the
// final top-of-stack or the index of the first instruction that broke it.
module calc_program_driver #(
  parameter int DEPTH  = 16,
  parameter int MAX_OP = 8,
  localparam int PW    = $clog2(DEPTH) + 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [3:0]    load_op,
  input  logic [7:0]    load_data,
  input  logic          load_clr,
  input  logic          start,
  output logic [PW-1:0] prog_len,
  output logic          prog_full,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] err_pc,
  output logic [7:0]    result,
  output logic          result_valid,
  output logic          calc_rst,
  output logic [7:0]    cmd_in,
  output logic [3:0]    cmd_op,
  output logic          cmd_apply,
  input  logic [7:0]    calc_head,
  input  logic          calc_empty,
  input  logic          calc_valid
);

  // The opcode port is 4 bits wide; a larger MAX_OP could not be encoded.
  if (MAX_OP > 15) begin : g_bad_max_op
    $error("calc_program_driver: MAX_OP does not fit the 4-bit opcode");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ISSUE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t         state_reg;
  logic [AW-1:0]  pc_reg;
  logic [AW-1:0]  pc_inc;
  logic           last_instr;
  logic           mem_we;

  // Program store: {opcode, operand}; contents survive reset.
  logic [11:0]    mem [DEPTH];

  assign prog_full  = (prog_len == PW'(DEPTH));
  assign pc_inc     = pc_reg + 1'b1;
  assign last_instr = ({1'b0, pc_reg} == (prog_len - 1'b1));

  // A load is only taken in IDLE when neither start nor clear claims the cycle.
  assign mem_we = (state_reg == IDLE) && !rst && !start && !load_clr &&
                  load_en && !prog_full;

  // Program memory write port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[prog_len[AW-1:0]] <= {load_op, load_data};
    end
  end

  // Sequencer: program length, run control and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      prog_len     <= '0;
      pc_reg       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_pc       <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      calc_rst     <= 1'b0;
      cmd_apply    <= 1'b0;
      cmd_op       <= '0;
      cmd_in       <= '0;
    end else begin
      done      <= 1'b0;
      calc_rst  <= 1'b0;
      cmd_apply <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            error        <= 1'b0;
            result_valid <= 1'b0;
            if (prog_len == '0) begin
              // Nothing to run: report completion straight away.
              state_reg <= DONE;
              done      <= 1'b1;
            end else begin
              state_reg <= CLEAR;
              pc_reg    <= '0;
              busy      <= 1'b1;
              calc_rst  <= 1'b1;
            end
          end else if (load_clr) begin
            prog_len <= '0;
          end else if (load_en && !prog_full) begin
            prog_len <= prog_len + 1'b1;
          end
        end
        CLEAR: begin
          state_reg        <= ISSUE;
          cmd_apply        <= 1'b1;
          {cmd_op, cmd_in} <= mem[pc_reg];
        end
        ISSUE: begin
          // Command stays on the bus while the calculator's flags settle.
          state_reg <= CHECK;
        end
        CHECK: begin
          if (!calc_valid || last_instr) begin
            state_reg <= DONE;
            done      <= 1'b1;
            busy      <= 1'b0;
            cmd_op    <= '0;
            cmd_in    <= '0;
            if (!calc_valid) begin
              error        <= 1'b1;
              err_pc       <= pc_reg;
              result_valid <= 1'b0;
            end else begin
              result       <= calc_head;
              result_valid <= !calc_empty;
            end
          end else begin
            state_reg        <= ISSUE;
            pc_reg           <= pc_inc;
            cmd_apply        <= 1'b1;
            {cmd_op, cmd_in} <= mem[pc_inc];
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_program_driver.sv
// Bench for calc_program_driver: a behavioural stack calculator answers the
// driver's commands, and a scoreboard checks each completed run.
module tb_calc_program_driver;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst, load_en, load_clr, start;
  logic [3:0] load_op;
  logic [7:0] load_data;
  logic [4:0] prog_len;
  logic       prog_full, busy, done, error, result_valid;
  logic [3:0] err_pc;
  logic [7:0] result;
  logic       calc_rst, cmd_apply;
  logic [7:0] cmd_in;
  logic [3:0] cmd_op;
  logic [7:0] calc_head;
  logic       calc_empty, calc_valid;

  calc_program_driver #(.DEPTH(DEPTH), .MAX_OP(8)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_op(load_op),
    .load_data(load_data), .load_clr(load_clr), .start(start),
    .prog_len(prog_len), .prog_full(prog_full), .busy(busy), .done(done),
    .error(error), .err_pc(err_pc), .result(result),
    .result_valid(result_valid), .calc_rst(calc_rst), .cmd_in(cmd_in),
    .cmd_op(cmd_op), .cmd_apply(cmd_apply), .calc_head(calc_head),
    .calc_empty(calc_empty), .calc_valid(calc_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural calculator: executes on apply, cleared by calc_rst, sticky valid.
  logic [7:0] st [64];
  int         sp = 0;
  bit         cv = 1'b1;
  logic [7:0] a, b;
  initial begin
    calc_head  = 8'd0;
    calc_empty = 1'b1;
    calc_valid = 1'b1;
  end
  always @(posedge clk) begin
    if (rst || calc_rst) begin
      sp = 0;
      cv = 1'b1;
    end else if (cmd_apply && cv) begin
      case (cmd_op)
        4'd0: begin st[sp] = cmd_in; sp++; end
        4'd1: if (sp < 1) cv = 1'b0; else sp--;
        4'd2: if (sp < 1) cv = 1'b0; else st[sp-1] = st[sp-1] + 8'd1;
        4'd3: if (sp < 1) cv = 1'b0; else st[sp-1] = st[sp-1] - 8'd1;
        4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
          if (sp < 2) cv = 1'b0;
          else begin
            a = st[sp-2];
            b = st[sp-1];
            if ((cmd_op == 4'd7 || cmd_op == 4'd8) && b == 8'd0) cv = 1'b0;
            else begin
              sp--;
              case (cmd_op)
                4'd4:    st[sp-1] = a + b;
                4'd5:    st[sp-1] = a * b;
                4'd6:    st[sp-1] = a - b;
                4'd7:    st[sp-1] = a / b;
                default: st[sp-1] = a % b;
              endcase
            end
          end
        end
        default: cv = 1'b0;
      endcase
    end
    calc_head  <= (sp > 0) ? st[sp-1] : 8'd0;
    calc_empty <= (sp == 0);
    calc_valid <= cv;
  end

  // Scoreboard entry: what one run must report, and when.
  typedef struct {
    logic       err;
    logic [3:0] pc;
    logic [7:0] res;
    logic       rv;
    int         done_cyc;
    int         applies;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   apply_cnt = 0;
  bit   busy_seen = 1'b0;
  bit   last_run_busy = 1'b0;

  // Monitor: count applies per run and score each done pulse.
  always @(negedge clk) begin
    if (rst) begin
      apply_cnt = 0;
      busy_seen = 1'b0;
    end else begin
      if (cmd_apply) apply_cnt++;
      if (busy) busy_seen = 1'b1;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("error", error, e.err);
          if (e.err) check("err_pc", err_pc, e.pc);
          check("result_valid", result_valid, e.rv);
          if (e.rv) check("result", result, e.res);
          check("done_cycle", cyc, e.done_cyc);
          check("applies", apply_cnt, e.applies);
          $display("run done at cycle %0d: error=%0b err_pc=%0d result=%0d result_valid=%0b applies=%0d",
                   cyc, error, err_pc, result, result_valid, apply_cnt);
        end
        last_run_busy = busy_seen;
        busy_seen = 1'b0;
        apply_cnt = 0;
      end
    end
  end

  // All stimulus tasks begin and end just after a falling edge.
  task automatic load(input logic [3:0] op, input logic [7:0] d);
    load_en = 1'b1; load_op = op; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
    $display("load op=%0d data=%0d -> prog_len=%0d", op, d, prog_len);
  endtask

  task automatic clr();
    load_clr = 1'b1;
    @(negedge clk);
    load_clr = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drain", exp_q.size(), 32'd0);
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic err, input logic [3:0] pc,
                     input logic [7:0] res, input logic rv, input bit with_load);
    exp_t x;
    int   issued;
    issued     = (n == 0) ? 0 : (err ? int'(pc) + 1 : n);
    x.err      = err;
    x.pc       = pc;
    x.res      = res;
    x.rv       = rv;
    x.applies  = issued;
    x.done_cyc = cyc + 1 + ((n == 0) ? 0 : 2 * issued + 1);
    exp_q.push_back(x);
    start   = 1'b1;
    load_en = with_load;
    load_op = 4'd0; load_data = 8'd55;
    @(negedge clk);
    start   = 1'b0;
    load_en = 1'b0;
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst = 1'b1; load_en = 1'b0; load_clr = 1'b0; start = 1'b0;
    load_op = 4'd0; load_data = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_prog_len", prog_len, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_err_pc", err_pc, 0);
    check("rst_result", result, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_calc_rst", calc_rst, 0);
    check("rst_cmd_apply", cmd_apply, 0);
    check("rst_cmd_op", cmd_op, 0);
    check("rst_cmd_in", cmd_in, 0);
    rst = 1'b0;
    @(negedge clk);

    // 6 * 7
    load(4'd0, 8'd6); load(4'd0, 8'd7); load(4'd5, 8'd0);
    check("len_after_3_loads", prog_len, 3);
    run(3, 1'b0, 4'd0, 8'd42, 1'b1, 1'b0);

    // divide by zero fails at instruction 2
    clr();
    load(4'd0, 8'd10); load(4'd0, 8'd0); load(4'd7, 8'd0);
    run(3, 1'b1, 4'd2, 8'd0, 1'b0, 1'b0);

    // push then pop leaves an empty stack
    clr();
    load(4'd0, 8'd3); load(4'd1, 8'd0);
    run(2, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);

    // full program, overflow load ignored, last slot executed
    clr();
    for (int i = 0; i < DEPTH; i++) load(4'd0, 8'(i + 1));
    check("full_prog_len", prog_len, DEPTH);
    check("full_flag", prog_full, 1);
    load(4'd0, 8'd99);
    check("overflow_prog_len", prog_len, DEPTH);
    run(DEPTH, 1'b0, 4'd0, 8'(DEPTH), 1'b1, 1'b0);
    clr();
    check("clr_prog_len", prog_len, 0);
    check("clr_full", prog_full, 0);

    // empty run with a simultaneous load: start wins, done next cycle
    run(0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b1);
    check("empty_run_busy", last_run_busy, 0);
    check("start_drops_load", prog_len, 0);

    // reset during the third ISSUE
    for (int i = 0; i < 5; i++) load(4'd0, 8'd1);
    load(4'd4, 8'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("clear_calc_rst", calc_rst, 1);
    check("clear_busy", busy, 1);
    seen = 0;
    for (int i = 0; i < 20 && seen < 3; i++) begin
      @(negedge clk);
      if (cmd_apply) seen++;
    end
    check("reached_issue3", seen, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun_busy", busy, 0);
    check("midrun_prog_len", prog_len, 0);
    check("midrun_cmd_apply", cmd_apply, 0);
    check("midrun_calc_rst", calc_rst, 0);
    check("midrun_cmd_op", cmd_op, 0);
    $display("mid-run reset applied at cycle %0d", cyc);
    @(negedge clk);

    // illegal opcode; rerun must give the same outcome
    load(4'd9, 8'd0);
    run(1, 1'b1, 4'd0, 8'd0, 1'b0, 1'b0);
    run(1, 1'b1, 4'd0, 8'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
